up_cou_mod: RTL and testbench
=============================

# up_cou_mod

Programmable-modulus 4-bit up counter: the counting-up counterpart of the team's down counter. It is intended for cascading, with a carry-out chaining several stages. It counts 0..mod_val and then wraps to 0, supports synchronous clear, parallel load and count-enable, and flags wrap events with a one-cycle pulse and a sticky overflow bit. It sits in the sequential-circuits counter set as the reusable building block for dividers and timers.

## Interface
Parameters:
- WIDTH, 4, counter width in bits.
- RST_VAL, 0, value of count after reset and after clear.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; advance by one when high.
- clr  input  1  synchronous clear to RST_VAL.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- mod_val  input  WIDTH  terminal value; sequence is 0..mod_val.
- ovf_ack  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count, registered.
- tc  output  1  combinational; (count >= mod_val) & en. Used as cascade carry into the next stage's en.
- wrap  output  1  registered one-cycle pulse, high the cycle after a wrap occurred.
- ovf  output  1  registered sticky flag, set on wrap.

## Operation
- Reset (rst=1, asynchronous, any time): count=RST_VAL, wrap=0, ovf=0. This takes effect immediately, without waiting for a clock edge, and holds while rst=1.
- Per rising edge, priority is clr > load > en > hold:
  - clr=1: count<=RST_VAL; wrap<=0; ovf unchanged.
  - load=1: count<=load_val; wrap<=0. load_val above mod_val is accepted as-is.
  - en=1 and count>=mod_val: count<=0; wrap<=1; ovf<=1.
  - en=1 otherwise: count<=count+1, modulo 2^WIDTH arithmetic, no wrap.
  - en=0: count holds; wrap<=0.
- mod_val=0: the counter stays at 0 with en=1, and tc and wrap are asserted every enabled cycle (divide-by-1).
- mod_val=2^WIDTH-1: plain free-running wrap 15→0 for WIDTH=4.
- Out-of-range count (count>mod_val, after a load or a mod_val change): the next enabled edge wraps to 0 and pulses wrap. The counter never counts up through the out-of-range region.
- ovf update:
  - ovf_ack=1 clears ovf.
  - If a wrap and ovf_ack occur on the same edge, set wins (ovf=1).
- mod_val is sampled every edge; changing it mid-count takes effect on the next edge.

## Timing
- count latency: 1 cycle from the en/load/clr edge.
- tc: zero-latency combinational and glitch-tolerant only within the cycle. Cascade stages sample it on the same clk.
- wrap: asserted exactly one cycle, coincident with count=0 after the wrap. Back-to-back wraps (mod_val=0, en held) keep wrap high continuously.
- ovf: set the cycle after the wrap edge. It clears the cycle after the ovf_ack edge.
- Reset deassertion: the first count edge is the first rising clk with rst=0.

## Structure
- Shared package cou_pkg: WIDTH default constant, RST_VAL default, and a next-state enum {CNT_HOLD, CNT_CLR, CNT_LOAD, CNT_INC, CNT_WRAP} used by the up and down counters alike.
- One natural sub-module, cou_next: a combinational next-state selector producing the enum plus next count from clr/load/en/count/mod_val. The top holds the registers, the wrap pulse and the sticky ovf.
- Two-stage cascade wrapper (stage0.tc → stage1.en) lives in the bench only, not in RTL.

## Test plan
- Reset: rst=1 mid-count at count=7, asynchronous, off a clock edge → count=0, wrap=0, ovf=0 immediately. After release with en=1, count reads 1,2,3 on successive edges.
- Mod wrap: mod_val=9, en=1 from 0 for 12 edges → count 1..9,0,1,2. wrap is high exactly one cycle, with count=0. ovf=1 afterwards. tc is high only while count=9.
- Priority: with count=5, drive clr=1, load=1 (load_val=12), en=1 together → count=0. Then load=1, en=1 → count=12. Then en=1 with mod_val=9 → count=0 and wrap=1.
- Boundaries:
  - mod_val=0, en=1 for 4 edges → count stays 0, wrap and tc high every cycle.
  - mod_val=15 → count goes 15→0 with wrap.
  - en=0 for 3 edges → count holds, wrap=0.
- ovf handshake: trigger a wrap → ovf=1. ovf_ack pulse → ovf=0 next cycle. ovf_ack on the same edge as a wrap → ovf remains 1.
- Cascade: two instances, stage0 mod_val=9, stage1 mod_val=5, stage1.en=stage0.tc. Run 60 edges → stage1 increments every 10 edges and stage1.wrap pulses once at edge 60.

Source files
------------

// File: rtl/cou_pkg.sv
// cou_pkg: shared counter defaults and the next-state operation enum for the up/down counters
package cou_pkg;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_RST_VAL = 0;
  typedef enum logic [2:0] {CNT_HOLD, CNT_CLR, CNT_LOAD, CNT_INC, CNT_WRAP} cnt_op_e;
endpackage

// File: rtl/up_cou_mod_if.sv
// up_cou_mod_if: counter control/status bundle; master drives en/clr/load/load_val/mod_val/ovf_ack, slave returns count/tc/wrap/ovf
interface up_cou_mod_if import cou_pkg::*; #(parameter int WIDTH = CNT_WIDTH) ();
  logic en;
  logic clr;
  logic load;
  logic ovf_ack;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] count;
  logic tc;
  logic wrap;
  logic ovf;
  modport master(output en, clr, load, ovf_ack, load_val, mod_val, input count, tc, wrap, ovf);
  modport slave(input en, clr, load, ovf_ack, load_val, mod_val, output count, tc, wrap, ovf);
endinterface

// File: rtl/cou_next.sv
// cou_next: picks the counter operation (clr > load > en > hold, wrap when count >= mod_val) and the resulting next count
module cou_next import cou_pkg::*; #(
  parameter int WIDTH = CNT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST_VAL)
) (
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_mod_val,
  input  logic [WIDTH-1:0] i_load_val,
  output cnt_op_e          o_op,
  output logic [WIDTH-1:0] o_nxt
);
  always_comb begin
    o_op = i_clr ? CNT_CLR : i_load ? CNT_LOAD : !i_en ? CNT_HOLD : (i_count >= i_mod_val) ? CNT_WRAP : CNT_INC;
    o_nxt = o_op == CNT_CLR  ? RST_VAL :
            o_op == CNT_LOAD ? i_load_val :
            o_op == CNT_WRAP ? '0 :
            o_op == CNT_INC  ? i_count + 1'b1 : i_count;
  end
endmodule

// File: rtl/up_cou_mod.sv
// up_cou_mod: programmable-modulus up counter (clk, rst, bus slave: count/tc/wrap pulse/sticky ovf)
module up_cou_mod import cou_pkg::*; #(
  parameter int WIDTH = CNT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST_VAL)
) (
  input logic clk,
  input logic rst,
  up_cou_mod_if.slave bus
);
  logic [WIDTH-1:0] r_count;
  logic r_wrap;
  logic r_ovf;
  cnt_op_e w_op;
  logic [WIDTH-1:0] w_nxt;
  cou_next #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_next (
    .i_clr(bus.clr),
    .i_load(bus.load),
    .i_en(bus.en),
    .i_count(r_count),
    .i_mod_val(bus.mod_val),
    .i_load_val(bus.load_val),
    .o_op(w_op),
    .o_nxt(w_nxt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
      r_wrap <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_count <= w_nxt;
      r_wrap <= w_op == CNT_WRAP;
      r_ovf <= (w_op == CNT_WRAP) | (r_ovf & ~bus.ovf_ack);
    end
  end
  assign bus.count = r_count;
  assign bus.wrap = r_wrap;
  assign bus.ovf = r_ovf;
  assign bus.tc = (r_count >= bus.mod_val) & bus.en;
endmodule

// File: tb/tb_up_cou_mod.sv
// tb_up_cou_mod: scoreboard bench for up_cou_mod plus a two-stage cascade
module tb_up_cou_mod;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  up_cou_mod_if #(4) bus();
  up_cou_mod_if #(4) c0();
  up_cou_mod_if #(4) c1();
  up_cou_mod u_dut(.clk(clk), .rst(rst), .bus(bus.slave));
  up_cou_mod u_s0(.clk(clk), .rst(rst), .bus(c0.slave));
  up_cou_mod u_s1(.clk(clk), .rst(rst), .bus(c1.slave));
  assign c1.en = c0.tc;
  typedef struct {int c; bit w; bit o; bit t;} exp_t;
  typedef struct {int a; int b; bit w;} cexp_t;
  exp_t q[$];
  cexp_t cq[$];
  int checks = 0;
  int failures = 0;
  int m_c = 0;
  bit m_w = 0;
  bit m_o = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(bit e, bit c, bit l, int lv, int mv, bit a);
    bit set;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.en = e;
    bus.clr = c;
    bus.load = l;
    bus.load_val = 4'(lv);
    bus.mod_val = 4'(mv);
    bus.ovf_ack = a;
    q.push_back('{m_c, m_w, m_o, bit'(e && m_c >= mv)});
    set = 0;
    if (c) begin m_c = 0; m_w = 0; end
    else if (l) begin m_c = lv; m_w = 0; end
    else if (e && m_c >= mv) begin m_c = 0; m_w = 1; set = 1; end
    else if (e) begin m_c = (m_c + 1) % 16; m_w = 0; end
    else m_w = 0;
    m_o = set ? 1'b1 : a ? 1'b0 : m_o;
  endtask
  task automatic do_rst();
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_c = 0;
    m_w = 0;
    m_o = 0;
    q.push_back('{0, 1'b0, 1'b0, bit'(bus.en && int'(bus.mod_val) == 0)});
  endtask
  initial begin : monitor
    exp_t e;
    cexp_t ce;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", int'(bus.count), e.c);
        chk("wrap", int'(bus.wrap), int'(e.w));
        chk("ovf", int'(bus.ovf), int'(e.o));
        chk("tc", int'(bus.tc), int'(e.t));
      end
      if (cq.size() > 0) begin
        ce = cq.pop_front();
        chk("cas_count0", int'(c0.count), ce.a);
        chk("cas_count1", int'(c1.count), ce.b);
        chk("cas_wrap1", int'(c1.wrap), int'(ce.w));
      end
    end
  end
  initial begin
    {bus.en, bus.clr, bus.load, bus.ovf_ack} = '0;
    bus.load_val = '0;
    bus.mod_val = 4'd15;
    {c0.clr, c0.load, c0.ovf_ack, c0.en, c1.clr, c1.load, c1.ovf_ack} = '0;
    c0.load_val = '0;
    c1.load_val = '0;
    c0.mod_val = 4'd9;
    c1.mod_val = 4'd5;
    repeat (2) @(posedge clk);
    drive(0, 0, 0, 0, 15, 0);
    repeat (7) drive(1, 0, 0, 0, 15, 0);
    do_rst();
    repeat (4) drive(1, 0, 0, 0, 15, 0);
    drive(0, 1, 0, 0, 9, 0);
    repeat (12) drive(1, 0, 0, 0, 9, 0);
    drive(0, 0, 1, 5, 9, 0);
    drive(1, 1, 1, 12, 9, 0);
    drive(1, 0, 1, 12, 9, 0);
    drive(1, 0, 0, 0, 9, 0);
    drive(0, 0, 0, 0, 9, 0);
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 14, 15, 0);
    repeat (3) drive(1, 0, 0, 0, 15, 0);
    repeat (4) drive(0, 0, 0, 0, 15, 0);
    drive(0, 0, 0, 0, 15, 1);
    drive(0, 0, 0, 0, 15, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    drive(0, 0, 0, 0, 15, 0);
    for (int n = 0; n <= 60; n++) begin
      @(posedge clk);
      #2;
      c0.en = 1'b1;
      cq.push_back('{n % 10, (n / 10) % 6, bit'(n == 60)});
    end
    @(posedge clk);
    #2;
    c0.en = 1'b0;
    for (int i = 0; i < 10 && (q.size() > 0 || cq.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() > 0 || cq.size() > 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", q.size() + cq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
